// File: rtl/ooo_issue_queue.sv
// Slot-based out-of-order ALU issue queue: CDB wakeup, oldest-first select into registered FU ports, full flush.
// Optional macro IQ_CDB_BYPASS_EN lets a source woken this cycle issue at once with its operand taken from the CDB.
module ooo_issue_queue #(
    parameter int IQ_SIZE     = 16,
    parameter int ISSUE_PORTS = 3,
    parameter int NUM_CDB     = 3,
    parameter int REG_SIZE    = 32,
    parameter int NUM_TAGS    = 64,
    parameter int ROB_SIZE    = 64,
    parameter int OP_W        = 4,
    localparam int TAG_W      = $clog2(NUM_TAGS),
    localparam int ROB_W      = $clog2(ROB_SIZE),
    localparam int CNT_W      = $clog2(IQ_SIZE + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [OP_W-1:0]                        in_op,
    input  logic [TAG_W-1:0]                       in_tag_rd,
    input  logic [ROB_W-1:0]                       in_rob_idx,
    input  logic [1:0][TAG_W-1:0]                  in_tag_rs,
    input  logic [1:0]                             in_rdy_rs,
    input  logic [1:0][REG_SIZE-1:0]               in_data_rs,
    input  logic [NUM_CDB-1:0]                     cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]          cdb_tag,
    input  logic [NUM_CDB-1:0][REG_SIZE-1:0]       cdb_data,
    input  logic [ISSUE_PORTS-1:0]                 fu_ready,
    output logic [ISSUE_PORTS-1:0]                 fu_valid,
    output logic [ISSUE_PORTS-1:0][OP_W-1:0]       fu_op,
    output logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]   fu_rs1,
    output logic [ISSUE_PORTS-1:0][REG_SIZE-1:0]   fu_rs2,
    output logic [ISSUE_PORTS-1:0][TAG_W-1:0]      fu_tag,
    output logic [ISSUE_PORTS-1:0][ROB_W-1:0]      fu_rob_idx,
    output logic [CNT_W-1:0]                       count
);
    localparam int IDX_W = $clog2(IQ_SIZE);

    logic [IQ_SIZE-1:0]              valid;
    logic [OP_W-1:0]                 e_op     [IQ_SIZE];
    logic [TAG_W-1:0]                e_tag_rd [IQ_SIZE];
    logic [ROB_W-1:0]                e_rob    [IQ_SIZE];
    logic [1:0][TAG_W-1:0]           e_tag_rs [IQ_SIZE];
    logic [1:0]                      e_rdy    [IQ_SIZE];
    logic [1:0][REG_SIZE-1:0]        e_data   [IQ_SIZE];
    // older[i][j] = 1 when entry j was dispatched before entry i
    logic [IQ_SIZE-1:0]              older    [IQ_SIZE];
    logic [CNT_W-1:0]                count_q;

    logic [1:0]                      wk_hit   [IQ_SIZE];
    logic [1:0][REG_SIZE-1:0]        wk_data  [IQ_SIZE];
    logic [1:0]                      src_ok   [IQ_SIZE];
    logic [1:0][REG_SIZE-1:0]        opnd     [IQ_SIZE];
    logic [IQ_SIZE-1:0]              elig;
    logic [IQ_SIZE-1:0]              taken;
    logic [ISSUE_PORTS-1:0]          sel_vld;
    logic [IDX_W-1:0]                sel_idx  [ISSUE_PORTS];
    logic [IDX_W-1:0]                alloc_idx;
    logic [IQ_SIZE-1:0]              alloc_oh;
    logic [CNT_W-1:0]                n_issued;
    logic                            dispatch;
    logic [1:0]                      in_hit;
    logic [1:0][REG_SIZE-1:0]        in_cdb_data;
    logic [1:0]                      new_rdy;
    logic [1:0][REG_SIZE-1:0]        new_data;

    // Returns {hit, data}; lowest CDB index wins, tag 0 never matches.
    function automatic logic [REG_SIZE:0] cdb_match(
        input logic [TAG_W-1:0]                  t,
        input logic [NUM_CDB-1:0]                v,
        input logic [NUM_CDB-1:0][TAG_W-1:0]     tg,
        input logic [NUM_CDB-1:0][REG_SIZE-1:0]  dt
    );
        logic [REG_SIZE:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (v[c] && tg[c] == t && t != '0) r = {1'b1, dt[c]};
        end
        return r;
    endfunction

    assign count    = count_q;
    assign in_ready = count_q < CNT_W'(IQ_SIZE);
    assign dispatch = in_valid && in_ready && !flush;

    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            for (int s = 0; s < 2; s++) begin
                {wk_hit[i][s], wk_data[i][s]} = cdb_match(e_tag_rs[i][s], cdb_valid, cdb_tag, cdb_data);
                src_ok[i][s] = e_rdy[i][s];
                opnd[i][s]   = e_data[i][s];
`ifdef IQ_CDB_BYPASS_EN
                if (!e_rdy[i][s] && wk_hit[i][s]) begin
                    src_ok[i][s] = 1'b1;
                    opnd[i][s]   = wk_data[i][s];
                end
`endif
            end
            elig[i] = valid[i] && (&src_ok[i]);
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            {in_hit[s], in_cdb_data[s]} = cdb_match(in_tag_rs[s], cdb_valid, cdb_tag, cdb_data);
            new_rdy[s]  = in_rdy_rs[s] || (in_tag_rs[s] == '0) || in_hit[s];
            new_data[s] = (!in_rdy_rs[s] && in_hit[s]) ? in_cdb_data[s] : in_data_rs[s];
        end
    end

    // Each ready port takes the eligible entry with no older untaken eligible entry.
    always_comb begin
        taken    = '0;
        n_issued = '0;
        for (int p = 0; p < ISSUE_PORTS; p++) begin
            sel_vld[p] = 1'b0;
            sel_idx[p] = '0;
            if (fu_ready[p]) begin
                for (int i = 0; i < IQ_SIZE; i++) begin
                    if (elig[i] && !taken[i] && ((older[i] & elig & ~taken) == '0)) begin
                        sel_vld[p] = 1'b1;
                        sel_idx[p] = IDX_W'(i);
                    end
                end
            end
            if (sel_vld[p]) taken[sel_idx[p]] = 1'b1;
            n_issued = n_issued + CNT_W'(sel_vld[p]);
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = IQ_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) alloc_idx = IDX_W'(i);
        end
        alloc_oh = dispatch ? (IQ_SIZE'(1) << alloc_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            count_q    <= '0;
            fu_valid   <= '0;
            fu_op      <= '0;
            fu_rs1     <= '0;
            fu_rs2     <= '0;
            fu_tag     <= '0;
            fu_rob_idx <= '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                older[i] <= '0;
                e_rdy[i] <= '0;
            end
        end else if (flush) begin
            valid    <= '0;
            count_q  <= '0;
            fu_valid <= '0;
        end else begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (valid[i] && !e_rdy[i][s] && wk_hit[i][s]) begin
                        e_rdy[i][s]  <= 1'b1;
                        e_data[i][s] <= wk_data[i][s];
                    end
                end
            end
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                fu_valid[p] <= sel_vld[p];
                if (sel_vld[p]) begin
                    fu_op[p]      <= e_op[sel_idx[p]];
                    fu_rs1[p]     <= opnd[sel_idx[p]][0];
                    fu_rs2[p]     <= opnd[sel_idx[p]][1];
                    fu_tag[p]     <= e_tag_rd[sel_idx[p]];
                    fu_rob_idx[p] <= e_rob[sel_idx[p]];
                end
            end
            if (dispatch) begin
                e_op[alloc_idx]     <= in_op;
                e_tag_rd[alloc_idx] <= in_tag_rd;
                e_rob[alloc_idx]    <= in_rob_idx;
                e_tag_rs[alloc_idx] <= in_tag_rs;
                e_rdy[alloc_idx]    <= new_rdy;
                e_data[alloc_idx]   <= new_data;
                older[alloc_idx]    <= valid;
                for (int i = 0; i < IQ_SIZE; i++) older[i][alloc_idx] <= 1'b0;
            end
            valid   <= (valid & ~taken) | alloc_oh;
            count_q <= count_q + CNT_W'(dispatch) - n_issued;
        end
    end

endmodule

// File: tb/tb_ooo_issue_queue.sv
// Directed bench for ooo_issue_queue: age-ordered list model checked every cycle plus literal spot checks.
module tb_ooo_issue_queue;
`ifdef IQ_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk, rst, flush, in_valid, in_ready;
    logic [3:0]        in_op;
    logic [5:0]        in_tag_rd, in_rob_idx;
    logic [1:0][5:0]   in_tag_rs;
    logic [1:0]        in_rdy_rs;
    logic [1:0][31:0]  in_data_rs;
    logic [2:0]        cdb_valid;
    logic [2:0][5:0]   cdb_tag;
    logic [2:0][31:0]  cdb_data;
    logic [2:0]        fu_ready, fu_valid;
    logic [2:0][3:0]   fu_op;
    logic [2:0][31:0]  fu_rs1, fu_rs2;
    logic [2:0][5:0]   fu_tag, fu_rob_idx;
    logic [4:0]        count;

    ooo_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag_rd(in_tag_rd), .in_rob_idx(in_rob_idx), .in_tag_rs(in_tag_rs),
        .in_rdy_rs(in_rdy_rs), .in_data_rs(in_data_rs), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .fu_ready(fu_ready), .fu_valid(fu_valid), .fu_op(fu_op),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_tag(fu_tag), .fu_rob_idx(fu_rob_idx), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       op;
        logic [5:0]       tag_rd;
        logic [5:0]       rob;
        logic [1:0][5:0]  tag;
        logic [1:0]       rdy;
        logic [1:0][31:0] data;
    } ment_t;

    ment_t            mq[$];
    logic [2:0]       e_vld;
    logic [2:0][3:0]  e_op;
    logic [2:0][31:0] e_rs1, e_rs2;
    logic [2:0][5:0]  e_tag, e_rob;
    int               n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic void cdb_lookup(input logic [5:0] t, output bit hit, output logic [31:0] d);
        hit = 0;
        d   = '0;
        for (int c = 0; c < 3; c++) begin
            if (!hit && cdb_valid[c] && cdb_tag[c] == t && t != 0) begin
                hit = 1;
                d   = cdb_data[c];
            end
        end
    endfunction

    function automatic bit src_ready(input ment_t e, input int s);
        bit hit;
        logic [31:0] d;
        cdb_lookup(e.tag[s], hit, d);
        return e.rdy[s] || (BYP && hit);
    endfunction

    function automatic logic [31:0] src_val(input ment_t e, input int s);
        bit hit;
        logic [31:0] d;
        cdb_lookup(e.tag[s], hit, d);
        return e.rdy[s] ? e.data[s] : d;
    endfunction

    // One clock of the specification's rules applied to an oldest-first list.
    task automatic model_cycle();
        ment_t nq[$];
        bit    taken[$];
        bit    done, hit;
        logic [31:0] d;
        ment_t e;
        int    sz;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            e_vld = '0; e_op = '0; e_rs1 = '0; e_rs2 = '0; e_tag = '0; e_rob = '0;
            return;
        end
        if (flush) begin
            mq.delete();
            e_vld = '0;
            return;
        end
        e_vld = '0;
        for (int k = 0; k < sz; k++) taken.push_back(1'b0);
        for (int p = 0; p < 3; p++) begin
            done = 0;
            if (fu_ready[p]) begin
                for (int k = 0; k < sz; k++) begin
                    if (!done && !taken[k] && src_ready(mq[k], 0) && src_ready(mq[k], 1)) begin
                        done     = 1;
                        taken[k] = 1;
                        e_vld[p] = 1'b1;
                        e_op[p]  = mq[k].op;
                        e_rs1[p] = src_val(mq[k], 0);
                        e_rs2[p] = src_val(mq[k], 1);
                        e_tag[p] = mq[k].tag_rd;
                        e_rob[p] = mq[k].rob;
                    end
                end
            end
        end
        for (int k = 0; k < sz; k++) begin
            if (!taken[k]) begin
                e = mq[k];
                for (int s = 0; s < 2; s++) begin
                    cdb_lookup(e.tag[s], hit, d);
                    if (!e.rdy[s] && hit) begin
                        e.rdy[s]  = 1'b1;
                        e.data[s] = d;
                    end
                end
                nq.push_back(e);
            end
        end
        if (in_valid && sz < 16) begin
            e.op = in_op; e.tag_rd = in_tag_rd; e.rob = in_rob_idx; e.tag = in_tag_rs;
            for (int s = 0; s < 2; s++) begin
                cdb_lookup(in_tag_rs[s], hit, d);
                e.rdy[s]  = in_rdy_rs[s] || in_tag_rs[s] == 0 || hit;
                e.data[s] = (!in_rdy_rs[s] && hit) ? d : in_data_rs[s];
            end
            nq.push_back(e);
        end
        mq = nq;
    endtask

    task automatic compare_all();
        chk("fu_valid", fu_valid, e_vld);
        for (int p = 0; p < 3; p++)
            chk($sformatf("fu_port%0d", p), {fu_op[p], fu_rs1[p], fu_rs2[p], fu_tag[p], fu_rob_idx[p]},
                {e_op[p], e_rs1[p], e_rs2[p], e_tag[p], e_rob[p]});
        chk("count", count, mq.size());
        chk("in_ready", in_ready, mq.size() < 16);
    endtask

    task automatic clear_in();
        rst = 0; flush = 0; in_valid = 0; in_op = 0; in_tag_rd = 0; in_rob_idx = 0;
        in_tag_rs = '0; in_rdy_rs = '0; in_data_rs = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [5:0] rob,
                            input logic [5:0] t1, input bit r1, input logic [31:0] d1,
                            input logic [5:0] t2, input bit r2, input logic [31:0] d2);
        in_valid = 1; in_op = op; in_rob_idx = rob; in_tag_rd = rob ^ 6'h2A;
        in_tag_rs[0] = t1; in_rdy_rs[0] = r1; in_data_rs[0] = d1;
        in_tag_rs[1] = t2; in_rdy_rs[1] = r2; in_data_rs[1] = d2;
    endtask

    task automatic set_cdb(input int c, input logic [5:0] t, input logic [31:0] d);
        cdb_valid[c] = 1'b1; cdb_tag[c] = t; cdb_data[c] = d;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        compare_all();
        clear_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clk = 0;
        fu_ready = '0;
        clear_in();
        rst = 1; step();
        rst = 1; step();
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fu", {fu_valid, fu_op, fu_rob_idx}, 0);

        // fill to full, reject a 17th, then drain three per cycle
        for (int i = 0; i < 16; i++) begin
            set_disp(4'(i), 6'(i), 6'd0, 1, 32'h100 + i, 6'd0, 1, 32'(i));
            step();
        end
        chk("fill_count", count, 16);
        chk("fill_in_ready", in_ready, 0);
        set_disp(4'hF, 6'd16, 6'd0, 1, 32'h1, 6'd0, 1, 32'h2);
        step();
        chk("full_reject", count, 16);
        fu_ready = 3'b111;
        step();
        chk("drain0", {fu_valid, fu_rob_idx[0], fu_rob_idx[1], fu_rob_idx[2]}, {3'b111, 6'd0, 6'd1, 6'd2});
        step();
        chk("drain1", {fu_valid, fu_rob_idx[0], fu_rob_idx[1], fu_rob_idx[2]}, {3'b111, 6'd3, 6'd4, 6'd5});
        for (int i = 0; i < 4; i++) step();
        chk("drain_empty", count, 0);

        // wakeup latency
        set_disp(4'h1, 6'd20, 6'd5, 0, 32'hDEAD, 6'd0, 1, 32'h10);
        step();
        set_cdb(1, 6'd5, 32'hA5);
        step();
        chk("wk_T1_vld", fu_valid[0], BYP);
        step();
        chk("wk_T2_vld", fu_valid[0], !BYP);
        chk("wk_ops", {fu_rs1[0], fu_rs2[0], fu_rob_idx[0]}, {32'hA5, 32'h10, 6'd20});

        // age order
        fu_ready = 3'b011;
        set_disp(4'h2, 6'd30, 6'd7, 0, 32'h0, 6'd0, 1, 32'h3);
        step();
        set_disp(4'h3, 6'd31, 6'd0, 1, 32'h31, 6'd0, 1, 32'h32);
        step();
        chk("age_none", fu_valid, 0);
        set_disp(4'h4, 6'd32, 6'd0, 1, 32'h41, 6'd8, 0, 32'h0);
        step();
        chk("age_B_first", {fu_valid, fu_rob_idx[0]}, {3'b001, 6'd31});
        set_cdb(0, 6'd7, 32'h77);
        set_cdb(2, 6'd8, 32'h88);
        step();
        chk("age_wake_cycle", fu_valid, BYP ? 3'b011 : 3'b000);
        step();
        chk("age_after", fu_valid, BYP ? 3'b000 : 3'b011);
        chk("age_A_C", {fu_rob_idx[0], fu_rs1[0], fu_rob_idx[1], fu_rs2[1]}, {6'd30, 32'h77, 6'd32, 32'h88});

        // port skip
        fu_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            set_disp(4'h5, 6'(40 + i), 6'd0, 1, 32'(i), 6'd0, 1, 32'h7);
            step();
        end
        fu_ready = 3'b101;
        step();
        chk("skip1", {fu_valid, fu_rob_idx[0], fu_rob_idx[2]}, {3'b101, 6'd40, 6'd41});
        step();
        chk("skip2", {fu_valid, fu_rob_idx[0], count}, {3'b001, 6'd42, 5'd0});

        // flush with dispatch and issue pending
        fu_ready = 3'b000;
        for (int i = 0; i < 8; i++) begin
            set_disp(4'h6, 6'(i), 6'd0, 1, 32'h5, 6'd0, 1, 32'h6);
            step();
        end
        chk("pre_flush_count", count, 8);
        set_disp(4'h7, 6'd60, 6'd0, 1, 32'h1, 6'd0, 1, 32'h1);
        flush = 1;
        fu_ready = 3'b111;
        step();
        chk("flush_state", {count, fu_valid}, 0);
        step();
        chk("flush_absent", {count, fu_valid}, 0);

        // tag 0, dispatch-cycle capture, CDB tag 0 ignored
        fu_ready = 3'b000;
        set_disp(4'h5, 6'd50, 6'd0, 0, 32'h50, 6'd0, 0, 32'h51);
        set_cdb(0, 6'd0, 32'hBAD);
        step();
        set_disp(4'h6, 6'd51, 6'd9, 0, 32'hDEAD, 6'd0, 1, 32'h3);
        set_cdb(2, 6'd9, 32'h99);
        step();
        set_disp(4'h7, 6'd52, 6'd12, 0, 32'h0, 6'd0, 1, 32'h4);
        set_cdb(1, 6'd0, 32'hBAD);
        step();
        fu_ready = 3'b111;
        step();
        chk("tag0_capture", {fu_valid, fu_rob_idx[0], fu_rs1[0], fu_rs2[0], fu_rob_idx[1], fu_rs1[1], fu_rs2[1]},
            {3'b011, 6'd50, 32'h50, 32'h51, 6'd51, 32'h99, 32'h3});
        chk("tag0_left", count, 1);
        set_cdb(0, 6'd12, 32'hC);
        step();
        step();
        chk("tag12_issue", {fu_rob_idx[0], fu_rs1[0], count}, {6'd52, 32'hC, 5'd0});

        // reset mid-operation
        fu_ready = 3'b000;
        set_disp(4'h8, 6'd1, 6'd0, 1, 32'h1, 6'd0, 1, 32'h1);
        step();
        set_disp(4'h9, 6'd2, 6'd0, 1, 32'h1, 6'd0, 1, 32'h1);
        step();
        set_disp(4'hA, 6'd3, 6'd0, 1, 32'h1, 6'd0, 1, 32'h1);
        flush = 1;
        rst = 1;
        fu_ready = 3'b111;
        step();
        chk("rst_mid", {count, fu_valid, fu_op, fu_rob_idx, fu_tag}, 0);
        chk("rst_mid_data", {fu_rs1, fu_rs2}, 0);
        step();
        chk("rst_mid_after", {count, fu_valid, in_ready}, {5'd0, 3'b000, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ooo_issue_queue.md
Name: ooo_issue_queue

Overview:
- Parametrised, slot-based out-of-order issue queue for integer ALU micro-ops. It sits between rename/dispatch and the ALU functional units.
- Accepts one micro-op per cycle over a valid/ready handshake. Wakes source operands from NUM_CDB result-bus broadcasts.
- Issues up to ISSUE_PORTS ready entries per cycle, oldest-first, into registered FU ports.
- Supports full pipeline flush.

Parameters:
- IQ_SIZE, 16, number of entries (power of two, >=2)
- ISSUE_PORTS, 3, FU issue ports
- NUM_CDB, 3, CDB broadcast ports
- REG_SIZE, 32, operand data width
- NUM_TAGS, 64, physical tag count; TAG_W = $clog2(NUM_TAGS)
- ROB_SIZE, 64, ROB entries; ROB_W = $clog2(ROB_SIZE)
- OP_W, 4, micro-op width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  queue can accept
- in_op  in  OP_W  micro-op
- in_tag_rd  in  TAG_W  destination tag
- in_rob_idx  in  ROB_W  ROB index
- in_tag_rs  in  2xTAG_W  source tags [0]=rs1, [1]=rs2
- in_rdy_rs  in  2  source already valid
- in_data_rs  in  2xREG_SIZE  source data (imm supplied here with rdy=1)
- cdb_valid  in  NUM_CDB  broadcast valid
- cdb_tag  in  NUM_CDBxTAG_W  broadcast tags
- cdb_data  in  NUM_CDBxREG_SIZE  broadcast data
- fu_ready  in  ISSUE_PORTS  FU can accept next cycle
- fu_valid  out  ISSUE_PORTS  issued op valid (one-cycle pulse)
- fu_op  out  ISSUE_PORTSxOP_W
- fu_rs1, fu_rs2  out  ISSUE_PORTSxREG_SIZE
- fu_tag  out  ISSUE_PORTSxTAG_W
- fu_rob_idx  out  ISSUE_PORTSxROB_W
- count  out  $clog2(IQ_SIZE+1)  occupied entries

Behaviour:
- Reset: all entries invalid, count=0, age state cleared, and every fu_* output is 0. in_ready=1 after reset.
- Entry state: valid, op, tag_rd, rob_idx, per-source {tag, rdy, data}, plus an IQ_SIZE x IQ_SIZE age matrix.
- Dispatch:
  - Fires when in_valid && in_ready && !flush. in_ready = (count < IQ_SIZE), from registered count only; issue in the same cycle gives no credit.
  - The new entry is written to the lowest-index free slot and marked younger than every valid entry.
- Tag 0:
  - A source tag of 0 is always ready; its data is taken from in_data_rs.
  - A CDB broadcast with tag 0 is ignored.
- Wakeup:
  - For each valid entry source with rdy=0, a match on any cdb_valid/cdb_tag sets rdy=1 and captures the data at the next edge.
  - Multiple matching CDB ports: the lowest index wins.
  - Dispatch-cycle capture: if an incoming non-ready source matches a CDB in its dispatch cycle, it is written ready with the CDB data.
- Eligibility: valid && both rdy, using registered state. A newly dispatched entry is never eligible in its dispatch cycle.
- Select:
  - Ports are considered in ascending index. Port p with fu_ready[p]=1 takes the oldest eligible entry not already taken by a lower port.
  - Ports with fu_ready=0 are skipped and do not consume an entry.
- Issue:
  - fu_* outputs are registered, so issue latency is 1 cycle from select.
  - A selected entry is invalidated at the same edge. fu_valid[p] is high for exactly one cycle per issue; the other fu_* fields hold their last values when fu_valid=0.
- count(next) = count + dispatch - issued. Simultaneous dispatch and issue are legal while full: no dispatch occurs, issue proceeds.
- Flush:
  - At the next edge all entries are invalidated, count=0, and fu_valid=0.
  - Dispatch and issue in the flush cycle are dropped. Flush has priority over everything except rst.
- rst mid-operation has the same result as reset, regardless of pending dispatch, issue or flush.

Optional Feature:
- Macro: IQ_CDB_BYPASS_EN.
- Defined: an entry whose missing source(s) match a valid CDB this cycle is eligible this cycle. The FU operand is taken directly from the matching cdb_data (lowest CDB index), so dependent ops issue back-to-back with the producer broadcast.
- Undefined: wakeup only updates entry state, and the entry becomes eligible the following cycle (one extra bubble).
- Select ordering and handshake rules are identical in both builds.

Test Plan:
- Fill and full: dispatch 16 ready ops with all fu_ready=0 → count=16, in_ready=0; a 17th in_valid is not accepted. Raise fu_ready=3'b111 → 3 ops per cycle issue in dispatch order, fu_rob_idx 0,1,2 then 3,4,5.
- Wakeup: dispatch op with rs1 tag 5 not ready, rs2 imm 0x10; cdb_valid[1]=1, tag 5, data 0xA5 at cycle T.
  - Without bypass: fu_valid at T+2 with fu_rs1=0xA5, fu_rs2=0x10.
  - With IQ_CDB_BYPASS_EN: fu_valid at T+1.
- Age order: dispatch A (waiting on tag 7) then B (ready), then broadcast tag 7 → B issues first on port 0; A issues on port 0 after wakeup. Newer C issues on port 1 in the same cycle as A only if C is also ready.
- Port skip: fu_ready=3'b101 with 3 ready ops → ports 0 and 2 each get one op (oldest to port 0); port 1 fu_valid stays 0; the third op issues the next cycle.
- Flush: 8 valid entries, flush asserted together with in_valid → next cycle count=0, fu_valid=0, and the dispatched op is absent.
- Tag 0 and dispatch capture: source tag 0 with in_rdy_rs=0 dispatches ready. Source tag 9 dispatched while cdb_tag=9 is valid is captured ready with the CDB data. A CDB tag 0 broadcast wakes nothing.
